sri_deserializer: RTL

- Serial receiver that pairs with the STI serial transmitter on the same so_data/so_valid link.
- Reconstructs parallel words from a bit stream qualified by a valid strobe.
- Supports 8-bit and 16-bit frames, MSB- or LSB-first bit order, and low- or high-half placement of 8-bit frames.
- Delivers each word through a one-entry valid/ready output buffer, flagging short frames and overruns.

---
 rtl/sri_deserializer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sri_deserializer.sv
// Serial-to-parallel receiver: rebuilds 8/16-bit words from a valid-qualified bit stream.
// Word is presented one clock after its last bit through a one-entry valid/ready buffer.
module sri_deserializer #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              si_data,
  input  logic              si_valid,
  input  logic              cfg_length,
  input  logic              cfg_msb,
  input  logic              cfg_low,
  output logic [DATA_W-1:0] po_data,
  output logic              po_valid,
  input  logic              po_ready,
  output logic              frame_err,
  output logic              overrun
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] FULL_LAST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] HALF_LAST = IDX_W'(DATA_W / 2 - 1);
  localparam logic [IDX_W-1:0] HALF_OFS  = IDX_W'(DATA_W / 2);

  typedef enum logic {IDLE, RECV} state_t;

  logic [1:0]        rst_sync_q, rst_sync_d;
  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              len_q, len_d;
  logic              msb_q, msb_d;
  logic              low_q, low_d;
  logic [DATA_W-1:0] po_data_q, po_data_d;
  logic              po_valid_q, po_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;

  logic              cur_len, cur_msb, cur_low;
  logic [IDX_W-1:0]  k, last, pos;
  logic [DATA_W-1:0] shift_nxt;
  logic              complete;

  always_comb begin
    rst_sync_d  = {rst_sync_q[0], 1'b1};
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    len_d       = len_q;
    msb_d       = msb_q;
    low_d       = low_q;
    po_data_d   = po_data_q;
    po_valid_d  = po_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    complete    = 1'b0;

    // In IDLE the incoming bit opens a frame, so the live cfg applies to it.
    cur_len = (state_q == IDLE) ? cfg_length : len_q;
    cur_msb = (state_q == IDLE) ? cfg_msb    : msb_q;
    cur_low = (state_q == IDLE) ? cfg_low    : low_q;
    k       = (state_q == IDLE) ? '0 : cnt_q;
    last    = cur_len ? FULL_LAST : HALF_LAST;
    pos     = cur_msb ? (last - k) : k;
    if (!cur_len && !cur_low) begin
      pos = pos + HALF_OFS;
    end
    shift_nxt = (state_q == IDLE) ? '0 : shift_q;

    if (si_valid) begin
      shift_nxt[pos] = si_data;
      len_d = cur_len;
      msb_d = cur_msb;
      low_d = cur_low;
      if (k == last) begin
        complete = 1'b1;
        state_d  = IDLE;
        cnt_d    = '0;
        shift_d  = '0;
      end else begin
        state_d = RECV;
        cnt_d   = k + IDX_W'(1);
        shift_d = shift_nxt;
      end
    end else if (state_q == RECV) begin
      frame_err_d = 1'b1;
      state_d     = IDLE;
      cnt_d       = '0;
      shift_d     = '0;
    end

    // A slot freed by this edge's handshake can take the new word directly.
    if (complete) begin
      if (!po_valid_q || po_ready) begin
        po_data_d  = shift_nxt;
        po_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (po_valid_q && po_ready) begin
      po_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      len_q       <= 1'b0;
      msb_q       <= 1'b0;
      low_q       <= 1'b0;
      po_data_q   <= '0;
      po_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (rst_sync_q[1]) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      len_q       <= len_d;
      msb_q       <= msb_d;
      low_q       <= low_d;
      po_data_q   <= po_data_d;
      po_valid_q  <= po_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign po_data   = po_data_q;
  assign po_valid  = po_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
